// File: rtl/trail_sequencer.sv
// Frame-rate scheduler for the phosphor-trail datapath: frame_no advances on vsync boundaries
// at a programmable rate/direction. Define TRAIL_AUTOREV_EN for ping-pong (auto-reverse) mode.
module trail_sequencer #(
    parameter int FRAME_W = 9,
    parameter int RATE_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync_in,
    input  logic               ctrl_valid,
    output logic               ctrl_ready,
    input  logic [7:0]         ctrl_data,
    output logic [FRAME_W-1:0] frame_no,
    output logic               frame_tick,
    output logic               paused,
    output logic               dir
);

    typedef enum logic [1:0] {
        OP_SET_RATE = 2'b00,
        OP_SET_DIR  = 2'b01,
        OP_PAUSE    = 2'b10,
        OP_STEP     = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_PAUSE = 2'b01,
        ST_STEP  = 2'b10
    } state_e;

    localparam logic [FRAME_W-1:0] FRAME_MAX = {FRAME_W{1'b1}};
    localparam logic [FRAME_W-1:0] FRAME_MIN = {FRAME_W{1'b0}};

    // Vsync synchronizer and rising-edge detect
    logic vs_meta;
    logic vs_sync;
    logic vs_prev;
    logic vs_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make this a true 3-flop shift chain;
            // blocking ones would collapse it into a single flop.
            vs_meta <= vsync_in;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign vs_rise = vs_sync & ~vs_prev;

    // One-entry command holding register
    logic        pend_full;
    logic [7:0]  pend_data;
    logic        cmd_accept;
    logic        cmd_apply;
    opcode_e     cmd_op;
    logic [5:0]  cmd_arg;

    assign ctrl_ready = ~pend_full;
    assign cmd_accept = ctrl_valid & ctrl_ready;
    assign cmd_apply  = vs_rise & pend_full;
    assign cmd_op     = opcode_e'(pend_data[7:6]);
    assign cmd_arg    = pend_data[5:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload is reset along with its valid flag so no stale
            // opcode survives a reset; it is a single register, not a memory array.
            pend_full <= 1'b0;
            pend_data <= 8'h00;
        end else if (cmd_apply) begin
            pend_full <= 1'b0;
        end else if (cmd_accept) begin
            pend_full <= 1'b1;
            pend_data <= ctrl_data;
        end
    end

    generate
        if (RATE_W < 6) begin : g_unused_arg
            logic unused_arg_bits;
            assign unused_arg_bits = ^cmd_arg[5:RATE_W];
        end
    endgenerate

    // Control state and frame datapath
    state_e              state;
    state_e              state_next;
    logic [RATE_W-1:0]   rate;
    logic [RATE_W-1:0]   rate_next;
    logic [RATE_W-1:0]   div_cnt;
    logic [RATE_W-1:0]   div_next;
    logic [FRAME_W-1:0]  frame_next;
    logic                dir_next;
    logic                advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        rate_next  = rate;
        div_next   = div_cnt;
        dir_next   = dir;
        frame_next = frame_no;
        advance    = 1'b0;

        // Advance decision uses the settings in force before this edge's command
        if (vs_rise) begin
            case (state)
                ST_RUN: begin
                    if (div_cnt == rate) begin
                        advance  = 1'b1;
                        div_next = '0;
                    end else begin
                        div_next = div_cnt + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    advance = 1'b0;
                end
                ST_STEP: begin
                    advance    = 1'b1;
                    state_next = ST_PAUSE;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end

        if (advance) begin
            frame_next = dir ? frame_no - 1'b1 : frame_no + 1'b1;
`ifdef TRAIL_AUTOREV_EN
            if (frame_next == (dir ? FRAME_MIN : FRAME_MAX)) begin
                dir_next = ~dir;
            end
`endif
        end

        // Command effects override the divider and any auto-reverse
        if (cmd_apply) begin
            case (cmd_op)
                OP_SET_RATE: begin
                    rate_next = cmd_arg[RATE_W-1:0];
                    div_next  = '0;
                end
                OP_SET_DIR: begin
                    dir_next = cmd_arg[0];
                end
                OP_PAUSE: begin
                    if (cmd_arg[0]) begin
                        state_next = ST_PAUSE;
                    end else begin
                        state_next = ST_RUN;
                        div_next   = '0;
                    end
                end
                OP_STEP: begin
                    if (state == ST_PAUSE) begin
                        state_next = ST_STEP;
                    end
                end
                default: begin
                    state_next = state_next;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate       <= '0;
            div_cnt    <= '0;
            dir        <= 1'b0;
            frame_no   <= '0;
            frame_tick <= 1'b0;
        end else begin
            rate       <= rate_next;
            div_cnt    <= div_next;
            dir        <= dir_next;
            frame_no   <= frame_next;
            frame_tick <= advance;
        end
    end

    assign paused = (state != ST_RUN);

endmodule
